// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Hardwired control unit for the bus datapath. It fetches an instruction,
//   decodes IR and steps the T-state sequence for ADD, SUB, MUL and HALT.
//   Control outputs are a Moore decode of the state register and the IR fields.
//   Nothing else is registered, so an asynchronous clear forces every output
//   low in the same cycle.
//
// Ports
//   clock                      system clock, rising edge
//   clear                      asynchronous active-high reset to IDLE
//   run                        1 = keep fetching, 0 = stop at instruction boundary
//   IR[31:0]                   datapath IR: [31:27] opc, [26:23] Ra, [22:19] Rb, [18:15] Rc
//   Rin[15:0] / Rout[15:0]     one-hot GPR load / bus-drive strobes (R0..R15)
//   PCin..Zlowout, MARin       register strobes
//   Read                       memory read (MDR loads memory data when Read & MDRin)
//   ALU_op[1:0]                00 ADD, 01 SUB, 10 MUL, 11 INC (Z <- bus + 1)
//   busy                       1 in any T-state
//   halted                     1 in HALT
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter logic [4:0] OPC_ADD  = 5'b00011,
    parameter logic [4:0] OPC_SUB  = 5'b00100,
    parameter logic [4:0] OPC_MUL  = 5'b01111,
    parameter logic [4:0] OPC_HALT = 5'b11011
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] IR,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCin,
    output logic        PCout,
    output logic        IRin,
    output logic        Yin,
    output logic        Yout,
    output logic        MDRin,
    output logic        MDRout,
    output logic        HIin,
    output logic        LOin,
    output logic        Zhighin,
    output logic        Zlowin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MARin,
    output logic        Read,
    output logic [1:0]  ALU_op,
    output logic        busy,
    output logic        halted
);

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;
    localparam logic [1:0] ALU_INC = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    state_t      state_r;
    logic [4:0]  opc_s;
    logic [3:0]  ra_s;
    logic [3:0]  rb_s;
    logic [3:0]  rc_s;
    logic        unused_ir_s;

    // Register index to one-hot strobe; R0 is an ordinary register.
    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    // ADD/SUB/MUL are the only opcodes that do work in T3..T5.
    function automatic logic is_alu_op(input logic [4:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_MUL);
    endfunction

    assign opc_s       = IR[31:27];
    assign ra_s        = IR[26:23];
    assign rb_s        = IR[22:19];
    assign rc_s        = IR[18:15];
    assign unused_ir_s = ^IR[14:0];

    // Sequencer state: steps T-states, async clear returns to IDLE.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (run) state_r <= ST_T0;
                    else     state_r <= ST_IDLE;
                end
                ST_T0:   state_r <= ST_T1;
                ST_T1:   state_r <= ST_T2;
                ST_T2:   state_r <= ST_T3;
                ST_T3: begin
                    if (opc_s == OPC_HALT) state_r <= ST_HALT;
                    else                   state_r <= ST_T4;
                end
                ST_T4:   state_r <= ST_T5;
                ST_T5: begin
                    // MUL needs one more step to move the high product word.
                    if (opc_s == OPC_MUL) state_r <= ST_T6;
                    else if (run)         state_r <= ST_T0;
                    else                  state_r <= ST_IDLE;
                end
                ST_T6: begin
                    if (run) state_r <= ST_T0;
                    else     state_r <= ST_IDLE;
                end
                ST_HALT: state_r <= ST_HALT;   // only clear leaves HALT
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Moore control decode from state and IR fields.
    always_comb begin
        Rin      = 16'h0000;
        Rout     = 16'h0000;
        PCin     = 1'b0;
        PCout    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Yout     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Zhighin  = 1'b0;
        Zlowin   = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        MARin    = 1'b0;
        Read     = 1'b0;
        ALU_op   = ALU_ADD;
        busy     = 1'b0;
        halted   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_T0: begin
                // MAR <- PC while the ALU forms PC+1 into Z.
                busy   = 1'b1;
                PCout  = 1'b1;
                MARin  = 1'b1;
                ALU_op = ALU_INC;
                Zlowin = 1'b1;
            end
            ST_T1: begin
                busy    = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_T2: begin
                busy   = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                busy = 1'b1;
                if (is_alu_op(opc_s)) begin
                    Rout = onehot16(rb_s);
                    Yin  = 1'b1;
                end else begin
                    Rout = 16'h0000;
                end
            end
            ST_T4: begin
                busy = 1'b1;
                case (opc_s)
                    OPC_ADD: begin
                        Rout   = onehot16(rc_s);
                        Zlowin = 1'b1;
                        ALU_op = ALU_ADD;
                    end
                    OPC_SUB: begin
                        Rout   = onehot16(rc_s);
                        Zlowin = 1'b1;
                        ALU_op = ALU_SUB;
                    end
                    OPC_MUL: begin
                        Rout    = onehot16(rc_s);
                        Zlowin  = 1'b1;
                        Zhighin = 1'b1;
                        ALU_op  = ALU_MUL;
                    end
                    default: begin
                        Rout = 16'h0000;
                    end
                endcase
            end
            ST_T5: begin
                busy = 1'b1;
                if (is_alu_op(opc_s)) begin
                    Zlowout = 1'b1;
                    if (opc_s == OPC_MUL) LOin = 1'b1;
                    else                  Rin  = onehot16(ra_s);
                end else begin
                    Zlowout = 1'b0;
                end
            end
            ST_T6: begin
                busy     = 1'b1;
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
